// File: rtl/cache_sdpb_alu54_pkg.sv
// Width constants shared by the frame-uploader cache and address adder.
package cache_sdpb_alu54_pkg;

  localparam int WR_WIDTH      = 16;
  localparam int WR_DEPTH_LOG2 = 4;
  localparam int RD_DEPTH_LOG2 = 3;
  localparam int ADD_A_WIDTH   = 21;
  localparam int ADD_B_WIDTH   = 11;
  localparam int RD_WIDTH      = 2 * WR_WIDTH;
  localparam int SUM_WIDTH     = ADD_A_WIDTH + 1;
  localparam int CASO_WIDTH    = 55;

endpackage

// File: rtl/cache_sdpb_alu54_addr_adder_reg.sv
// Registered unsigned adder A + zero-extended B, carry kept in the top bit.
module addr_adder_reg
  import cache_sdpb_alu54_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic [ADD_A_WIDTH-1:0] a,
  input  logic [ADD_B_WIDTH-1:0] b,
  output logic [SUM_WIDTH-1:0]   sum
);

  logic [SUM_WIDTH-1:0] sum_reg;
  logic [SUM_WIDTH-1:0] sum_next;

  assign sum_next = {1'b0, a} + {{(SUM_WIDTH - ADD_B_WIDTH){1'b0}}, b};

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_reg <= '0;
    end else if (ce) begin
      sum_reg <= sum_next;
    end
  end

  assign sum = sum_reg;

endmodule

// File: rtl/cache_sdpb_alu54.sv
// Pixel cache (16x16 write, 8x32 read) plus registered frame-address adder.
module cache_sdpb_alu54
  import cache_sdpb_alu54_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cache_cea,
  input  logic [WR_DEPTH_LOG2-1:0] cache_ada,
  input  logic [WR_WIDTH-1:0]      cache_din,
  input  logic                     cache_ceb,
  input  logic [RD_DEPTH_LOG2-1:0] cache_adb,
  input  logic                     cache_oce,
  output logic [RD_WIDTH-1:0]      cache_dout,
  input  logic                     add_ce,
  input  logic [ADD_A_WIDTH-1:0]   add_a,
  input  logic [ADD_B_WIDTH-1:0]   add_b,
  output logic [SUM_WIDTH-1:0]     add_dout,
  output logic [CASO_WIDTH-1:0]    add_caso
);

  // Output register runs in bypass mode, so the enable has no effect.
  logic unused_oce;
  assign unused_oce = cache_oce;

  logic [RD_DEPTH_LOG2-1:0] wr_word_addr;
  assign wr_word_addr = cache_ada[WR_DEPTH_LOG2-1:1];

  // Even and odd halfwords live in separate banks so one read fetches a full
  // word; the non-blocking read/write pair gives read-before-write on collision.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [WR_WIDTH-1:0] bank_mem [2**RD_DEPTH_LOG2];
      logic [WR_WIDTH-1:0] rd_half_reg;
      logic                wr_en;

      assign wr_en = cache_cea && !reset && (cache_ada[0] == (gi != 0));

      always_ff @(posedge clk) begin
        if (wr_en) begin
          bank_mem[wr_word_addr] <= cache_din;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_half_reg <= '0;
        end else if (cache_ceb) begin
          rd_half_reg <= bank_mem[cache_adb];
        end
      end

      assign cache_dout[gi*WR_WIDTH +: WR_WIDTH] = rd_half_reg;
    end
  endgenerate

  addr_adder_reg u_addr_adder (
    .clk   (clk),
    .reset (reset),
    .ce    (add_ce),
    .a     (add_a),
    .b     (add_b),
    .sum   (add_dout)
  );

  assign add_caso = '0;

endmodule

// File: tb/tb_cache_sdpb_alu54.sv
// Self-checking bench: directed vector table, hand sequences, random vs model.
module tb_cache_sdpb_alu54;

  logic        clk = 1'b0;
  logic        reset;
  logic        cache_cea;
  logic [3:0]  cache_ada;
  logic [15:0] cache_din;
  logic        cache_ceb;
  logic [2:0]  cache_adb;
  logic        cache_oce;
  logic [31:0] cache_dout;
  logic        add_ce;
  logic [20:0] add_a;
  logic [10:0] add_b;
  logic [21:0] add_dout;
  logic [54:0] add_caso;

  always #5 clk = ~clk;

  cache_sdpb_alu54 dut (
    .clk        (clk),
    .reset      (reset),
    .cache_cea  (cache_cea),
    .cache_ada  (cache_ada),
    .cache_din  (cache_din),
    .cache_ceb  (cache_ceb),
    .cache_adb  (cache_adb),
    .cache_oce  (cache_oce),
    .cache_dout (cache_dout),
    .add_ce     (add_ce),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_dout   (add_dout),
    .add_caso   (add_caso)
  );

  typedef struct {
    logic        rst;
    logic        cea;
    logic [3:0]  ada;
    logic [15:0] din;
    logic        ceb;
    logic [2:0]  adb;
    logic        ace;
    logic [20:0] a;
    logic [10:0] b;
    logic [31:0] exp_dout;
    logic [21:0] exp_add;
  } vec_t;

  vec_t vecs[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural reference: halfword array plus the two output values.
  int unsigned m_mem [16];
  int unsigned m_dout;
  int unsigned m_add;

  function automatic vec_t mk(logic rst, logic cea, logic [3:0] ada, logic [15:0] din,
                              logic ceb, logic [2:0] adb, logic ace, logic [20:0] a,
                              logic [10:0] b, logic [31:0] ed, logic [21:0] ea);
    vec_t v;
    v.rst = rst; v.cea = cea; v.ada = ada; v.din = din; v.ceb = ceb; v.adb = adb;
    v.ace = ace; v.a = a; v.b = b; v.exp_dout = ed; v.exp_add = ea;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    reset = v.rst; cache_cea = v.cea; cache_ada = v.ada; cache_din = v.din;
    cache_ceb = v.ceb; cache_adb = v.adb; add_ce = v.ace; add_a = v.a; add_b = v.b;
  endtask

  // One clock edge; the model computes the new outputs from the pre-edge memory.
  task automatic step();
    int unsigned nd;
    int unsigned na;
    nd = m_dout;
    na = m_add;
    if (reset) begin
      nd = 0;
      na = 0;
    end else begin
      if (cache_ceb) nd = m_mem[2*cache_adb+1] * 65536 + m_mem[2*cache_adb];
      if (cache_cea) m_mem[cache_ada] = cache_din;
      if (add_ce) na = add_a + add_b;
    end
    @(posedge clk);
    m_dout = nd;
    m_add  = na;
    #1;
  endtask

  initial begin
    vec_t v;
    cache_oce = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    m_dout = 0;
    m_add  = 0;

    // Directed table: fill, burst read, collision, hold, adder cases.
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(0, 1, 4'(i), 16'(32'h1000 + i), 0, 0, 0, 0, 0, 32'h0, 22'h0));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 0, 0, 0, 1, 3'(k), 0, 0, 0,
                        {16'(32'h1000 + 2*k + 1), 16'(32'h1000 + 2*k)}, 22'h0));
    vecs.push_back(mk(0, 1, 4'd2, 16'hBEEF, 1, 3'd1, 0, 0, 0, 32'h10031002, 22'h0));
    vecs.push_back(mk(0, 0, 4'd9, 16'h1234, 1, 3'd1, 0, 0, 0, 32'h1003BEEF, 22'h0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 0, 4'd5, 16'hDEAD, 0, 3'(k + 4), 0, 21'h0ABCDE, 11'h123,
                        32'h1003BEEF, 22'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 21'h000100, 11'd16, 32'h1003BEEF, 22'h000110));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 21'h005555, 11'd3,  32'h1003BEEF, 22'h000110));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 21'h1FFFFF, 11'd1,  32'h1003BEEF, 22'h200000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 21'h1FFFF0, 11'h7FF, 32'h1003BEEF, 22'h2007EF));

    // Arbitrary activity, then two reset cycles with every enable asserted.
    for (int i = 0; i < 3; i++) begin
      drive(mk(0, 1, 4'($urandom_range(15)), 16'($urandom), 0, 0, 1,
               21'($urandom), 11'($urandom), 0, 0));
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(mk(1, 0, 0, 0, 1, 3'($urandom_range(7)), 1, 21'($urandom), 11'($urandom), 0, 0));
      step();
      $display("reset cycle %0d: dout=0x%08h add=0x%06h", i, cache_dout, add_dout);
      check("reset_dout", 64'(cache_dout), 64'h0);
      check("reset_add", 64'(add_dout), 64'h0);
    end
    for (int i = 0; i < 2; i++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 0, 21'($urandom), 11'($urandom), 0, 0));
      step();
      $display("idle cycle %0d: dout=0x%08h add=0x%06h", i, cache_dout, add_dout);
      check("idle_dout", 64'(cache_dout), 64'h0);
      check("idle_add", 64'(add_dout), 64'h0);
    end

    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v);
      step();
      $display("vec %0d: dout=0x%08h add=0x%06h", i, cache_dout, add_dout);
      check($sformatf("vec%0d_dout", i), 64'(cache_dout), 64'(v.exp_dout));
      check($sformatf("vec%0d_add", i), 64'(add_dout), 64'(v.exp_add));
      check($sformatf("vec%0d_caso", i), 64'(add_caso), 64'h0);
    end

    // Reset on the same edge as a read and an add, then memory survives.
    drive(mk(1, 0, 0, 0, 1, 3'd0, 1, 21'h000321, 11'd5, 0, 0));
    step();
    $display("mid reset: dout=0x%08h add=0x%06h", cache_dout, add_dout);
    check("midrst_dout", 64'(cache_dout), 64'h0);
    check("midrst_add", 64'(add_dout), 64'h0);
    drive(mk(0, 0, 0, 0, 1, 3'd0, 0, 21'h000321, 11'd5, 0, 0));
    step();
    $display("post reset read: dout=0x%08h add=0x%06h", cache_dout, add_dout);
    check("post_rst_read", 64'(cache_dout), 64'h10011000);
    check("post_rst_add", 64'(add_dout), 64'h0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      drive(mk(($urandom_range(31) == 0), 1'($urandom), 4'($urandom), 16'($urandom),
               1'($urandom), 3'($urandom), 1'($urandom), 21'($urandom), 11'($urandom), 0, 0));
      step();
      $display("rand %0d: dout=0x%08h add=0x%06h", i, cache_dout, add_dout);
      check($sformatf("rand%0d_dout", i), 64'(cache_dout), 64'(m_dout));
      check($sformatf("rand%0d_add", i), 64'(add_dout), 64'(m_add));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
